// File: rtl/btn_pkg.sv
// Shared definitions for the button command queue: direction indices and the
// opposite-direction helper used by the optional reverse filter (REVERSE_FILTER_EN).
package btn_pkg;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;

    // Channels pair as opposites (0/1, 2/3, ...).
    function automatic int unsigned opposite(input int unsigned ch);
        return ch ^ 32'd1;
    endfunction

endpackage

// File: rtl/btn_cmd_queue_if.sv
// Button/command bus between the board-side driver and btn_cmd_queue.
interface btn_cmd_queue_if #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [NUM_CH-1:0] Btn_raw;
    logic              Tick;
    logic [NUM_CH-1:0] Btn_level;
    logic [NUM_CH-1:0] Btn_pulse;
    logic              Cmd_valid;
    logic [CH_W-1:0]   Cmd_ch;
    logic [CNT_W-1:0]  Count;
    logic              Overflow;

    modport master (
        output Btn_raw, Tick,
        input  Btn_level, Btn_pulse, Cmd_valid, Cmd_ch, Count, Overflow
    );

    modport slave (
        input  Btn_raw, Tick,
        output Btn_level, Btn_pulse, Cmd_valid, Cmd_ch, Count, Overflow
    );
endinterface

// File: rtl/btn_debounce.sv
// Single-channel 2-flop synchroniser, hold-time debounce counter and
// rising-edge pulse decode.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;

    // Level only moves after s2 has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            s1_q         <= raw_i;
            s2_q         <= s1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign pulse_o = level_q & ~level_prev_q;

endmodule

// File: rtl/btn_cmd_queue.sv
// Debounced button front end with a small press-event FIFO drained on game ticks.
// Optional opposite-direction rejection is enabled with REVERSE_FILTER_EN.
module btn_cmd_queue
    import btn_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned QUEUE_DEPTH     = 4
) (
    input logic              Clk,
    input logic              Reset_n,
    btn_cmd_queue_if.slave   bus
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] pulse;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (Clk),
            .rst_n   (Reset_n),
            .raw_i   (bus.Btn_raw[g]),
            .level_o (level[g]),
            .pulse_o (pulse[g])
        );
    end

    logic [CH_W-1:0]  mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cmd_valid_q;
    logic [CH_W-1:0]  cmd_ch_q, cmd_ch_d;
    logic             overflow_q, overflow_d;

    logic [CH_W-1:0]  cand;
    logic             cand_vld;
    logic [CH_W-1:0]  tail;
    logic             non_empty, full;
    logic             dup, rev_drop, accept, push, pop;

`ifdef REVERSE_FILTER_EN
    logic [CH_W-1:0]  last_pop_q;
    logic [CH_W-1:0]  ref_ch;
`endif

    // Lowest-indexed pulsing channel wins; the rest are discarded.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pulse[i]) begin
                cand     = CH_W'(i);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        non_empty  = (count_q != '0);
        full       = (count_q == CNT_W'(QUEUE_DEPTH));
        tail       = mem_q[wr_ptr_q - PTR_W'(1)];
        dup        = non_empty && (cand == tail);
`ifdef REVERSE_FILTER_EN
        ref_ch     = non_empty ? tail : last_pop_q;
        rev_drop   = (cand == CH_W'(opposite(32'(ref_ch))));
`else
        rev_drop   = 1'b0;
`endif
        accept     = cand_vld && !dup && !rev_drop;
        pop        = bus.Tick && non_empty;
        push       = accept && (!full || pop);
        overflow_d = overflow_q || (accept && full && !pop);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Next head may be the entry being written this cycle.
        if (count_d == '0) begin
            cmd_ch_d = '0;
        end else if (push && (rd_ptr_d == wr_ptr_q)) begin
            cmd_ch_d = cand;
        end else begin
            cmd_ch_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= cand;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_valid_q <= (count_d != '0);
            cmd_ch_q    <= cmd_ch_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef REVERSE_FILTER_EN
    // Direction reference used when the queue is empty.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_pop_q <= CH_W'(DIR_RIGHT);
        end else if (pop) begin
            last_pop_q <= mem_q[rd_ptr_q];
        end
    end
`endif

    assign bus.Btn_level = level;
    assign bus.Btn_pulse = pulse;
    assign bus.Cmd_valid = cmd_valid_q;
    assign bus.Cmd_ch    = cmd_ch_q;
    assign bus.Count     = count_q;
    assign bus.Overflow  = overflow_q;

endmodule

// File: tb/tb_btn_cmd_queue.sv
// Scoreboard bench for btn_cmd_queue: directed presses, with a negedge monitor
// checking every pulse and every popped command against expected queues.
module tb_btn_cmd_queue;

    localparam int unsigned NCH = 4;
    localparam int unsigned DC  = 4;
    localparam int unsigned QD  = 2;
`ifdef REVERSE_FILTER_EN
    localparam bit RF = 1'b1;
`else
    localparam bit RF = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    btn_cmd_queue_if #(.NUM_CH(NCH), .QUEUE_DEPTH(QD)) bus ();

    btn_cmd_queue #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (DC),
        .QUEUE_DEPTH     (QD)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_pop   [$];
    logic [3:0] exp_pulse [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        bus.Tick = 1'b1;
        cyc(1);
        bus.Tick = 1'b0;
    endtask

    // Full press: hold until queued, then release and let the level fall.
    task automatic press(input int ch);
        bus.Btn_raw[ch] = 1'b1;
        exp_pulse.push_back(4'(1 << ch));
        cyc(7);
        bus.Btn_raw[ch] = 1'b0;
        cyc(7);
    endtask

    // Monitor: every pulse and every pop is matched against the scoreboard.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.Btn_pulse != '0) begin
                if (exp_pulse.size() == 0)
                    chk("pulse_unexpected", 32'(bus.Btn_pulse), 32'd0);
                else
                    chk("pulse", 32'(bus.Btn_pulse), 32'(exp_pulse.pop_front()));
            end
            if (bus.Tick && bus.Cmd_valid) begin
                if (exp_pop.size() == 0)
                    chk("pop_unexpected", 32'(bus.Cmd_ch), 32'hFFFF);
                else
                    chk("pop_ch", 32'(bus.Cmd_ch), 32'(exp_pop.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Btn_raw = '0;
        bus.Tick    = 1'b0;
        Reset_n     = 1'b0;
        cyc(3);
        chk("rst_level",    32'(bus.Btn_level), 32'd0);
        chk("rst_pulse",    32'(bus.Btn_pulse), 32'd0);
        chk("rst_valid",    32'(bus.Cmd_valid), 32'd0);
        chk("rst_ch",       32'(bus.Cmd_ch),    32'd0);
        chk("rst_count",    32'(bus.Count),     32'd0);
        chk("rst_overflow", 32'(bus.Overflow),  32'd0);
        Reset_n = 1'b1;

        // Latency: raw[2] before edge k -> pulse after k+5, queued after k+6.
        bus.Btn_raw[2] = 1'b1;
        exp_pulse.push_back(4'b0100);
        cyc(5);
        chk("lat_pulse_k4", 32'(bus.Btn_pulse), 32'd0);
        chk("lat_level_k4", 32'(bus.Btn_level), 32'd0);
        cyc(1);
        chk("lat_pulse_k5", 32'(bus.Btn_pulse), 32'h4);
        chk("lat_valid_k5", 32'(bus.Cmd_valid), 32'd0);
        cyc(1);
        chk("lat_pulse_k6", 32'(bus.Btn_pulse), 32'd0);
        chk("lat_valid_k6", 32'(bus.Cmd_valid), RF ? 32'd0 : 32'd1);
        chk("lat_ch_k6",    32'(bus.Cmd_ch),    RF ? 32'd0 : 32'd2);
        bus.Btn_raw[2] = 1'b0;
        cyc(7);
        if (!RF) exp_pop.push_back(2'd2);
        tick();
        chk("lat_drained", 32'(bus.Cmd_valid), 32'd0);

        // Glitch of three cycles must not qualify.
        bus.Btn_raw[0] = 1'b1;
        cyc(3);
        bus.Btn_raw[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("glitch_level", 32'(bus.Btn_level), 32'd0);
        end
        chk("glitch_valid", 32'(bus.Cmd_valid), 32'd0);

        // Fill the queue and overflow it.
        press(0);
        press(2);
        press(1);
        chk("full_count", 32'(bus.Count),    32'd2);
        chk("full_ovf",   32'(bus.Overflow), 32'd1);
        chk("full_head",  32'(bus.Cmd_ch),   32'd0);
        exp_pop.push_back(2'd0);
        exp_pop.push_back(2'd2);
        tick();
        chk("full_head2",  32'(bus.Cmd_ch), 32'd2);
        chk("full_count1", 32'(bus.Count),  32'd1);
        tick();
        chk("full_empty",  32'(bus.Cmd_valid), 32'd0);
        chk("full_count0", 32'(bus.Count),     32'd0);
        chk("ovf_sticky",  32'(bus.Overflow),  32'd1);

        // Asynchronous reset mid-debounce with raw[3] held.
        bus.Btn_raw[3] = 1'b1;
        cyc(3);
        Reset_n = 1'b0;
        #1;
        chk("arst_ovf",   32'(bus.Overflow),  32'd0);
        chk("arst_level", 32'(bus.Btn_level), 32'd0);
        chk("arst_count", 32'(bus.Count),     32'd0);
        cyc(2);
        Reset_n = 1'b1;
        exp_pulse.push_back(4'b1000);
        cyc(5);
        chk("arst_pulse_k4", 32'(bus.Btn_pulse), 32'd0);
        cyc(1);
        chk("arst_pulse_k5", 32'(bus.Btn_pulse), 32'h8);
        cyc(1);
        chk("arst_ch", 32'(bus.Cmd_ch), 32'd3);
        bus.Btn_raw[3] = 1'b0;
        cyc(7);
        exp_pop.push_back(2'd3);
        tick();
        chk("arst_drained", 32'(bus.Cmd_valid), 32'd0);

        // Simultaneous pulses on 1 and 3: only 1 is queued.
        bus.Btn_raw[1] = 1'b1;
        bus.Btn_raw[3] = 1'b1;
        exp_pulse.push_back(4'b1010);
        cyc(7);
        chk("simul_count", 32'(bus.Count),  32'd1);
        chk("simul_ch",    32'(bus.Cmd_ch), 32'd1);
        bus.Btn_raw[1] = 1'b0;
        bus.Btn_raw[3] = 1'b0;
        cyc(7);

        // Repeat of the tail entry is suppressed.
        press(1);
        chk("dup_count", 32'(bus.Count), 32'd1);
        press(2);
        chk("two_count", 32'(bus.Count), 32'd2);

        // Full queue, push and Tick on the same edge.
        bus.Btn_raw[0] = 1'b1;
        exp_pulse.push_back(4'b0001);
        cyc(6);
        exp_pop.push_back(2'd1);
        tick();
        chk("pp_count", 32'(bus.Count),    32'd2);
        chk("pp_ovf",   32'(bus.Overflow), 32'd0);
        chk("pp_head",  32'(bus.Cmd_ch),   32'd2);
        bus.Btn_raw[0] = 1'b0;
        cyc(7);
        exp_pop.push_back(2'd2);
        tick();
        chk("pp_head2", 32'(bus.Cmd_ch), 32'd0);
        exp_pop.push_back(2'd0);
        tick();
        chk("pp_empty", 32'(bus.Cmd_valid), 32'd0);

`ifdef REVERSE_FILTER_EN
        // Reference is Right after reset: Left dropped, Up kept, then Down dropped.
        Reset_n = 1'b0;
        cyc(1);
        Reset_n = 1'b1;
        press(2);
        chk("rf_left_dropped", 32'(bus.Count), 32'd0);
        press(0);
        chk("rf_up_count", 32'(bus.Count),  32'd1);
        chk("rf_up_ch",    32'(bus.Cmd_ch), 32'd0);
        press(1);
        chk("rf_down_dropped", 32'(bus.Count), 32'd1);
        exp_pop.push_back(2'd0);
        tick();
`endif

        cyc(2);
        chk("pulses_seen", 32'(exp_pulse.size()), 32'd0);
        chk("pops_seen",   32'(exp_pop.size()),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
